// File: rtl/picorv32_soc_pkg.sv
// Shared types and constants for the PicoRV32 SoC memory arbiter.
// Holds the arbiter FSM state type, the grant encoding and the
// read data returned to a master whose transaction timed out.
package picorv32_soc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_e;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // One-hot {M1,M0} view of a grant, as presented on o_grant.
    function automatic logic [1:0] grant_onehot(input grant_e g);
        return (g == GNT_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/picorv32_bus_watchdog.sv
// Bus watchdog for the memory arbiter.
// Counts cycles while enabled and flags expiry once the count reaches
// TIMEOUT_CYCLES-1. The count is cleared when a new transaction starts
// and holds at the limit so it can never wrap.
module picorv32_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cycle counter: cleared on transaction start, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Two-master / one-slave arbiter on the PicoRV32 native memory bus.
// M0 is the CPU core, M1 the UART boot/debug loader. One transaction is
// outstanding at a time; contention is resolved round-robin.
// Optional bus watchdog: define PICORV32_ARB_TIMEOUT_EN to enable it.
module picorv32_mem_arbiter
    import picorv32_soc_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_m0_valid,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_wstrb,
    output logic                o_m0_ready,
    output logic [DATA_W-1:0]   o_m0_rdata,

    input  logic                i_m1_valid,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_wstrb,
    output logic                o_m1_ready,
    output logic [DATA_W-1:0]   o_m1_rdata,

    output logic                o_s_valid,
    output logic [ADDR_W-1:0]   o_s_addr,
    output logic [DATA_W-1:0]   o_s_wdata,
    output logic [DATA_W/8-1:0] o_s_wstrb,
    input  logic                i_s_ready,
    input  logic [DATA_W-1:0]   i_s_rdata,

    output logic [1:0]          o_grant,
    output logic                o_timeout
);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    grant_e            last_q, last_d;
    grant_e            pick;

    logic              busy;
    logic              owner_valid;
    logic              done_ok;
    logic              done_to;
    logic              resp;
    logic [DATA_W-1:0] resp_rdata;
    logic              expire;

    assign busy    = (state_q == BUSY);
    assign o_grant = grant_q;

`ifdef PICORV32_ARB_TIMEOUT_EN
    logic wd_clear;

    // Restart the watchdog on the edge that opens a new transaction.
    assign wd_clear = (state_q == IDLE) && (state_d == BUSY);

    picorv32_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (i_clk),
        .rst    (i_rst),
        .clear  (wd_clear),
        .enable (busy),
        .expire (expire)
    );
`else
    // No watchdog: a stalled slave holds the bus until the owner gives up.
    assign expire = 1'b0;
`endif

    // FSM state, current owner and round-robin history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= GNT_M1;   // so M0 wins the first tie
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitrate in IDLE, release the bus in BUSY on
    // completion, timeout, or the owner withdrawing its request.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        pick    = GNT_M0;
        case (state_q)
            IDLE: begin
                if (i_m0_valid || i_m1_valid) begin
                    if (i_m0_valid && i_m1_valid) begin
                        pick = (last_q == GNT_M0) ? GNT_M1 : GNT_M0;
                    end else begin
                        pick = i_m1_valid ? GNT_M1 : GNT_M0;
                    end
                    state_d = BUSY;
                    grant_d = grant_onehot(pick);
                    last_d  = pick;
                end
            end
            BUSY: begin
                if (resp || !owner_valid || expire) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Slave request mux and completion routing on the registered owner.
    always_comb begin
        owner_valid = 1'b0;
        o_s_addr    = '0;
        o_s_wdata   = '0;
        o_s_wstrb   = '0;
        if (grant_q[0]) begin
            owner_valid = i_m0_valid;
            o_s_addr    = i_m0_addr;
            o_s_wdata   = i_m0_wdata;
            o_s_wstrb   = i_m0_wstrb;
        end else if (grant_q[1]) begin
            owner_valid = i_m1_valid;
            o_s_addr    = i_m1_addr;
            o_s_wdata   = i_m1_wdata;
            o_s_wstrb   = i_m1_wstrb;
        end

        // A request withdrawn by its owner disappears from the slave at once.
        o_s_valid = busy && owner_valid;

        // A slave response on the expiry cycle counts as a normal completion.
        done_ok    = o_s_valid && i_s_ready;
        done_to    = o_s_valid && !i_s_ready && expire;
        resp       = done_ok || done_to;
        resp_rdata = done_ok ? i_s_rdata : DATA_W'(ARB_TIMEOUT_RDATA);

        o_m0_ready = resp && grant_q[0];
        o_m1_ready = resp && grant_q[1];
        o_m0_rdata = o_m0_ready ? resp_rdata : '0;
        o_m1_rdata = o_m1_ready ? resp_rdata : '0;
        o_timeout  = done_to;
    end

endmodule
